// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB slave memory
//
// Purpose: holds the slave FSM state encoding and the fixed memory depth used
// by apb_slave_mem and its testbench.
// Ports: none (package).
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_slv_state_t;

  localparam int APB_SLV_DEPTH = 16;

  // Reset value of the wait-state LFSR; any non-zero seed keeps it cycling.
  localparam logic [3:0] APB_SLV_LFSR_SEED = 4'hE;

endpackage

// File: rtl/apb_slv_lfsr.sv
// rtl/apb_slv_lfsr.sv - 4-bit maximal-length LFSR used to draw wait states
//
// Purpose: Fibonacci LFSR for polynomial x^4 + x^3 + 1, stepping every cycle.
// Ports:
//   clk     in   clock, state advances on posedge
//   reset   in   asynchronous active-low reset, loads APB_SLV_LFSR_SEED
//   lfsr_o  out  current 4-bit LFSR state
module apb_slv_lfsr
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] lfsr_o
);

  logic [3:0] lfsr_q;
  logic [3:0] lfsr_d;

  // Taps at stages 4 and 3 give the full 15-state cycle.
  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= APB_SLV_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave backed by a 16 x 32-bit register memory
//
// Purpose: decodes a 256-byte window at BASE_ADDR and serves APB reads and
// writes to 16 words. Out-of-window accesses complete with pslverr_o=1.
// Optional macro APB_SLAVE_WAIT_EN: inserts 0-3 pseudo-random wait cycles per
// transfer from an apb_slv_lfsr instance; without it every access phase
// completes in its first cycle.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   psel_i     in   APB select
//   penable_i  in   APB enable (access phase)
//   paddr_i    in   byte address [31:0]; [1:0] and [7:6] are don't-care
//   pwrite_i   in   1 = write, 0 = read
//   pwdata_i   in   write data [31:0]
//   pready_o   out  transfer complete
//   prdata_o   out  read data [31:0], zero unless completing an in-window read
//   pslverr_o  out  error response, only while pready_o=1
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hDEAD_CA00,
  parameter int          DEPTH     = APB_SLV_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  apb_slv_state_t state_q;
  apb_slv_state_t state_d;
  logic [1:0]     wait_q;
  logic [1:0]     wait_d;
  logic [31:0]    mem_q [DEPTH];
  logic [31:0]    mem_d [DEPTH];

  logic [1:0]     wait_load;
  logic           hit;
  logic [3:0]     word_idx;
  logic           do_write;

  // Address bits outside the decode compare and the word index.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^{paddr_i[7:6], paddr_i[1:0]};

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] lfsr;

  apb_slv_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr[3:2];
  assign wait_load = lfsr[1:0];
`else
  assign wait_load = 2'd0;
`endif

  assign hit      = (paddr_i[31:8] == BASE_ADDR[31:8]);
  assign word_idx = paddr_i[5:2];

  // Completion is combinational so a zero-wait transfer finishes in the
  // first access cycle; state_q is cleared asynchronously, so reset forces
  // every response output low at once.
  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = 32'h0;
    if ((state_q == ST_ACCESS) && psel_i && penable_i && (wait_q == 2'd0)) begin
      pready_o  = 1'b1;
      pslverr_o = !hit;
      if (hit && !pwrite_i) begin
        prdata_o = mem_q[word_idx];
      end
    end
  end

  assign do_write = pready_o && pwrite_i && hit;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        // penable_i without a preceding setup phase is ignored here.
        if (psel_i && !penable_i) begin
          state_d = ST_ACCESS;
          wait_d  = wait_load;
        end
      end
      ST_ACCESS: begin
        if (!psel_i || pready_o) begin
          // Abandoned or completed; IDLE can accept the next setup phase
          // in the following cycle.
          state_d = ST_IDLE;
          wait_d  = 2'd0;
        end else if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = 2'd0;
      end
    endcase
  end

  // The write lands on the completing edge, so a read in the very next
  // transfer already sees the new word.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_write) begin
      mem_d[word_idx] = pwdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hDEAD_CA00: base of the 256-byte decode window; only paddr_i[31:8] is compared.
REQ-002 SHALL have parameter DEPTH, default 16: number of 32-bit words, fixed at 16 (index paddr_i[5:2]).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port psel_i  input  1  APB select.
REQ-006 SHALL have port penable_i  input  1  APB enable (access phase).
REQ-007 SHALL have port paddr_i  input  32  byte address; bits [1:0] and [7:6] ignored.
REQ-008 SHALL have port pwrite_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port pwdata_i  input  32  write data.
REQ-010 SHALL have port pready_o  output  1  transfer complete.
REQ-011 SHALL have port prdata_o  output  32  read data, valid only while pready_o=1 on a read.
REQ-012 SHALL have port pslverr_o  output  1  error response, valid only while pready_o=1.

Function
REQ-013 SHALL implement states ST_IDLE and ST_ACCESS.
REQ-014 ST_IDLE -> ST_ACCESS on psel_i=1, penable_i=0 (setup phase); the wait counter is loaded in the same edge.
REQ-015 ST_ACCESS: pready_o=1 combinationally when psel_i=1, penable_i=1 and wait counter==0; otherwise the counter decrements by 1 per cycle, saturating at 0.
REQ-016 ST_ACCESS -> ST_IDLE on the cycle pready_o=1 is sampled; the next setup phase is accepted in the immediately following cycle (back-to-back, no dead cycle).
REQ-017 If psel_i drops while in ST_ACCESS before completion: SHALL return to ST_IDLE; no write, no response.
REQ-018 Hit = paddr_i[31:8]==BASE_ADDR[31:8]; word index = paddr_i[5:2].
REQ-019 Write on hit: mem[index] <= pwdata_i at the edge where pready_o=1; pslverr_o=0.
REQ-020 Read on hit: prdata_o = mem[index] while pready_o=1; otherwise prdata_o=32'h0.
REQ-021 Miss: pready_o per REQ-015, pslverr_o=1, prdata_o=32'h0, memory unchanged.
REQ-022 Read and write of the same word in consecutive transfers: the read SHALL return the newly written value (no forwarding hazard).
REQ-023 penable_i=1 seen in ST_IDLE (protocol violation) SHALL be ignored: no state change, no response.

Reset
REQ-024 On reset=0: state=ST_IDLE, wait counter=0, all 16 memory words=32'h0, pready_o=0, pslverr_o=0, prdata_o=32'h0, LFSR=4'hE.
REQ-025 Reset asserted mid-transfer SHALL abort it without committing the write; outputs take reset values immediately (asynchronously).

Configuration
REQ-026 Macro APB_SLAVE_WAIT_EN defined: 4-bit LFSR (x^4+x^3+1, advances every cycle) supplies wait count = LFSR[1:0] at setup, giving 0-3 wait cycles per transfer.
REQ-027 Macro undefined: wait count always 0, so pready_o=1 in the first access cycle; the LFSR is not instantiated.

Structure
REQ-028 Package apb_pkg SHALL hold the state enum apb_slv_state_t (ST_IDLE=1'b0, ST_ACCESS=1'b1) and the constant APB_SLV_DEPTH=16.
REQ-029 The LFSR SHALL be the sub-module apb_slv_lfsr (clk, reset, lfsr_o[3:0]), instantiated only under APB_SLAVE_WAIT_EN.

Verification
REQ-030 Write 32'h1234_5678 to 32'hDEAD_CA04, then read 32'hDEAD_CA04 -> prdata_o=32'h1234_5678, pslverr_o=0.
REQ-031 Read 32'hDEAD_CAFE directly after reset -> prdata_o=32'h0 (word 15), pslverr_o=0.
REQ-032 Write 32'hFFFF_FFFF to 32'h0000_0004 -> pslverr_o=1 with pready_o; a subsequent read of 32'hDEAD_CA04 still returns the prior value.
REQ-033 100 back-to-back transfers -> macro undefined: every access lasts exactly 1 cycle; macro defined: 1-4 cycles each and at least two distinct lengths observed.
REQ-034 Write to 32'hDEAD_CA08 with reset pulsed low during the access phase -> pready_o=0 immediately; a read of 32'hDEAD_CA08 after release returns 32'h0.
REQ-035 psel_i dropped in the access phase of a write to 32'hDEAD_CA0C -> FSM in ST_IDLE next cycle, no pready_o, word 3 unchanged.
